// File: rtl/seven_seg_pkg.sv
// Shared constants for the 7-segment scan controller: state encoding, blank pattern and
// the active-low hex glyph table.
package seven_seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    // Segment order {g,f,e,d,c,b,a}, active-low, indexed by hex digit 0..F.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seven_seg.sv
// Combinational hex to active-low 7-segment decoder.
module seven_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode display scanner with inter-digit blanking, leading-zero
// blanking and frame-synchronous value updates through a load/ready handshake.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned PRESCALE   = 50000,
    parameter int unsigned BLANK_CYC  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_blank,
    output logic                    ready,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int unsigned CW = $clog2(PRESCALE);
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(PRESCALE - BLANK_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    boundary;

    logic [4*NUM_DIGITS-1:0] disp_q, pend_val_q;
    logic [NUM_DIGITS-1:0]   dpr_q, pend_dp_q;
    logic                    pend_q, lz_q;

    logic [NUM_DIGITS-1:0]   lead_zero;
    logic                    zero_run;
    logic [3:0]              sel_nib;
    logic                    sel_dp, sel_blank;
    logic [6:0]              dec_seg;

    logic [NUM_DIGITS-1:0]   an_d, an_q;
    logic [6:0]              seg_d, seg_q;
    logic                    dp_d, dp_q, frame_done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BLANK;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                end
            end
            ST_SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                end
            end
        endcase
    end

    assign boundary = (state_q == ST_SHOW) && (cnt_q == SHOW_LAST) && (idx_q == IDX_LAST);

    // lead_zero[i] is set when digits NUM_DIGITS-1 down to i are all zero.
    always_comb begin
        zero_run  = 1'b1;
        lead_zero = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run     = zero_run & (disp_q[4*i +: 4] == 4'h0);
            lead_zero[i] = zero_run;
        end
    end

    always_comb begin
        sel_nib   = '0;
        sel_dp    = 1'b0;
        sel_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                sel_nib   = disp_q[4*i +: 4];
                sel_dp    = dpr_q[i];
                sel_blank = lz_q & lead_zero[i];
            end
        end
    end

    seven_seg u_dec (
        .hex (sel_nib),
        .seg (dec_seg)
    );

    always_comb begin
        an_d  = '1;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (state_q == ST_SHOW && !sel_blank) begin
            an_d  = ~(NUM_DIGITS'(1) << idx_q);
            seg_d = dec_seg;
            dp_d  = ~sel_dp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an_q         <= '1;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
            disp_q       <= '0;
            dpr_q        <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_q       <= 1'b0;
            lz_q         <= 1'b0;
        end else begin
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= boundary;
            if (state_q == ST_BLANK && cnt_q == '0) begin
                lz_q <= lz_blank;
            end
            // A load arriving on the boundary cycle itself waits for the next boundary.
            if (boundary && pend_q) begin
                disp_q <= pend_val_q;
                dpr_q  <= pend_dp_q;
                pend_q <= 1'b0;
            end else if (load && !pend_q) begin
                pend_val_q <= value;
                pend_dp_q  <= dp_in;
                pend_q     <= 1'b1;
            end
        end
    end

    assign ready      = ~pend_q;
    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan: per-cycle reference model plus directed checks.
module tb_seven_seg_scan;

    localparam int N     = 4;
    localparam int P     = 8;
    localparam int B     = 2;
    localparam int FRAME = N * P;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic        lz_blank = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic        ready, dp, frame_done;
    logic [6:0]  seg;
    logic [3:0]  an;

    seven_seg_scan #(
        .NUM_DIGITS (N),
        .PRESCALE   (P),
        .BLANK_CYC  (B)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .lz_blank   (lz_blank),
        .ready      (ready),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int off     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: time since reset gives the frame position; slot/digit by division.
    int          t = -1;
    bit          valid = 1'b0;
    int          m_p, m_slot, m_within;
    logic [15:0] m_disp, m_pval;
    logic [3:0]  m_dpr, m_pdp, m_nib;
    bit          m_pend, m_lz;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_fd, e_rdy;

    initial begin
        forever begin
            @(negedge clk);
            if (valid) begin
                chk("m_an", an, e_an);
                chk("m_seg", seg, e_seg);
                chk("m_dp", dp, e_dp);
                chk("m_frame_done", frame_done, e_fd);
                chk("m_ready", ready, e_rdy);
            end
            if (rst) begin
                t = 0; m_disp = '0; m_dpr = '0; m_pend = 1'b0; m_pval = '0; m_pdp = '0;
                m_lz = 1'b0;
                e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0; e_rdy = 1'b1;
                valid = 1'b1;
            end else if (valid) begin
                m_p      = t % FRAME;
                m_slot   = m_p / P;
                m_within = m_p % P;
                e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
                if (m_within >= B && !(m_lz && m_slot > 0 && (m_disp >> (4 * m_slot)) == 0)) begin
                    m_nib = m_disp[4*m_slot +: 4];
                    e_an  = ~(4'b0001 << m_slot);
                    e_seg = SEG_TAB[m_nib];
                    e_dp  = ~m_dpr[m_slot];
                end
                e_fd = (m_p == FRAME - 1);
                if (m_within == 0) m_lz = lz_blank;
                if (m_p == FRAME - 1 && m_pend) begin
                    m_disp = m_pval; m_dpr = m_pdp; m_pend = 1'b0;
                end else if (load && !m_pend) begin
                    m_pval = value; m_pdp = dp_in; m_pend = 1'b1;
                end
                e_rdy = !m_pend;
                t++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
        off += n;
    endtask

    task automatic goto(input int o);
        if (o > off) step(o - off);
    endtask

    task automatic wait_frame();
        int k;
        k = 0;
        step(1);
        while (frame_done !== 1'b1 && k < 40) begin
            step(1);
            k++;
        end
        chk("frame_wait", frame_done, 1);
        off = 0;
    endtask

    task automatic load_val(input logic [15:0] v, input logic [3:0] d);
        value = v; dp_in = d; load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    // From frame offset 0: check each digit early in its visible window.
    task automatic check_slots(input string name, input logic [15:0] ans, input logic [27:0] segs,
                               input logic [3:0] dps);
        for (int d = 0; d < 4; d++) begin
            goto(3 + 8 * d);
            chk($sformatf("%s_an%0d", name, d), an, ans[4*d +: 4]);
            chk($sformatf("%s_seg%0d", name, d), seg, segs[7*d +: 7]);
            chk($sformatf("%s_dp%0d", name, d), dp, dps[d]);
        end
    endtask

    task automatic scan_frame(output logic [3:0] lows, output logic [15:0] ans,
                              output logic [27:0] segs);
        lows = '0; ans = '0; segs = '0;
        for (int s = 1; s <= FRAME; s++) begin
            step(1);
            lows |= ~an;
            if (s % P == 3) begin
                ans[4*(s/P) +: 4]  = an;
                segs[7*(s/P) +: 7] = seg;
            end
        end
        chk("scan_end_fd", frame_done, 1);
        off = 0;
    endtask

    logic [3:0]  lows;
    logic [15:0] sans;
    logic [27:0] ssegs;

    initial begin
        step(3);
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_ready", ready, 1);
        chk("rst_dp", dp, 1);
        rst = 1'b0;
        step(2);
        chk("pre_show_an", an, 4'hF);
        step(1);
        chk("first_an", an, 4'b1110);
        chk("first_seg", seg, 7'h40);
        step(28);
        chk("fd_early", frame_done, 0);
        step(1);
        chk("fd_first", frame_done, 1);
        off = 0;

        load_val(16'h1234, 4'b0100);
        chk("ready_low", ready, 0);
        goto(31);
        chk("ready_still_low", ready, 0);
        wait_frame();
        chk("ready_back", ready, 1);
        check_slots("v1234", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                    {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1011);

        load_val(16'hAAAA, 4'h0);
        load_val(16'hBBBB, 4'h0);
        wait_frame();
        load_val(16'hBBBB, 4'h0);
        check_slots("vAAAA", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                    {7'h08, 7'h08, 7'h08, 7'h08}, 4'b1111);
        wait_frame();
        check_slots("vBBBB", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                    {7'h03, 7'h03, 7'h03, 7'h03}, 4'b1111);

        lz_blank = 1'b1;
        load_val(16'h0070, 4'h0);
        wait_frame();
        scan_frame(lows, sans, ssegs);
        chk("lz70_lows", lows, 4'b0011);
        chk("lz70_an", sans, {4'b1111, 4'b1111, 4'b1101, 4'b1110});
        chk("lz70_seg", ssegs, {7'h7F, 7'h7F, 7'h78, 7'h40});
        load_val(16'h0000, 4'h0);
        wait_frame();
        scan_frame(lows, sans, ssegs);
        chk("lz0_lows", lows, 4'b0001);
        chk("lz0_seg0", ssegs[6:0], 7'h40);

        lz_blank = 1'b0;
        load_val(16'h5555, 4'hF);
        goto(20);
        chk("pre_rst_an", an, 4'b1011);
        rst = 1'b1;
        step(1);
        chk("midrst_an", an, 4'hF);
        chk("midrst_seg", seg, 7'h7F);
        chk("midrst_ready", ready, 1);
        rst = 1'b0;
        off = 0;
        step(3);
        chk("restart_an", an, 4'b1110);
        chk("restart_seg", seg, 7'h40);
        wait_frame();
        check_slots("discard", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                    {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111);

        goto(31);
        value = 16'hCCCC; dp_in = 4'h0; load = 1'b1;
        step(1);
        load = 1'b0;
        chk("bnd_fd", frame_done, 1);
        chk("bnd_ready", ready, 0);
        off = 0;
        check_slots("bnd_old", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                    {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111);
        wait_frame();
        check_slots("bnd_new", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                    {7'h46, 7'h46, 7'h46, 7'h46}, 4'b1111);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
